// File: rtl/packet_identifier_lanes.sv
// packet_identifier_lanes
// Multi-lane registered framing classifier. Each cycle LANES received bytes
// (lane 0 first on the wire) are classified as TLP/DLLP start, data, end,
// nullified end or not-valid. Framing state and the data-byte count are
// carried from lane to lane inside the cycle and across cycles through
// registers. All outputs are registered, giving one clock of latency.
//
// Optional feature: define PKT_ID_STATS_EN to add saturating 16-bit
// counters of tlpend, dllpend, tlpedb and error lanes (tlp_cnt, dllp_cnt,
// edb_cnt, err_cnt). Without the macro those ports and their logic are absent.

module packet_identifier_lanes #(
    parameter int LANES         = 4,
    parameter int MAX_TLP_BYTES = 4096,
    parameter int DLLP_BYTES    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*LANES-1:0]   data_in,
    input  logic [LANES-1:0]     dk_in,
    input  logic [LANES-1:0]     valid_in,
    output logic [6*LANES-1:0]   type_out,
    output logic [LANES-1:0]     valid_out,
    output logic [LANES-1:0]     err_out,
`ifdef PKT_ID_STATS_EN
    output logic [15:0]          tlp_cnt,
    output logic [15:0]          dllp_cnt,
    output logic [15:0]          edb_cnt,
    output logic [15:0]          err_cnt,
`endif
    output logic [1:0]           state_out
);

    // Counter is wide enough to hold MAX_TLP_BYTES+1 so overflow is detectable.
    localparam int CW = $clog2(MAX_TLP_BYTES + 2);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_TLP_BYTES);
    localparam logic [CW-1:0] DLLP_C   = CW'(DLLP_BYTES);

    // K symbol codes
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_PAD = 8'hF7;

    // One-hot lane type codes
    localparam logic [5:0] T_NONE      = 6'b000000;
    localparam logic [5:0] T_DATA      = 6'b100000;
    localparam logic [5:0] T_TLPSTART  = 6'b010000;
    localparam logic [5:0] T_TLPEND    = 6'b001000;
    localparam logic [5:0] T_DLLPEND   = 6'b000100;
    localparam logic [5:0] T_DLLPSTART = 6'b000010;
    localparam logic [5:0] T_TLPEDB    = 6'b000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TLP  = 2'b01,
        ST_DLLP = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [6*LANES-1:0]    type_q, type_d;
    logic [LANES-1:0]      valid_q, valid_d;
    logic [LANES-1:0]      err_q, err_d;

    logic [7:0]            byte_s;
    logic [5:0]            lane_type_s;
    logic                  lane_err_s;

    // Lane chain: walk lanes in wire order, each seeing the state left by the previous one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = {(6*LANES){1'b0}};
        err_d       = {LANES{1'b0}};
        valid_d     = valid_in;
        byte_s      = 8'h00;
        lane_type_s = T_NONE;
        lane_err_s  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            byte_s      = data_in[8*i +: 8];
            lane_type_s = T_NONE;
            lane_err_s  = 1'b0;
            if (!valid_in[i]) begin
                // Invalid lane: state and count pass through untouched.
                lane_type_s = T_NONE;
            end else if (dk_in[i]) begin
                case (byte_s)
                    K_STP: begin
                        lane_type_s = T_TLPSTART;
                        lane_err_s  = (state_d != ST_IDLE);
                        state_d     = ST_TLP;
                        cnt_d       = CNT_ZERO;
                    end
                    K_SDP: begin
                        lane_type_s = T_DLLPSTART;
                        lane_err_s  = (state_d != ST_IDLE);
                        state_d     = ST_DLLP;
                        cnt_d       = CNT_ZERO;
                    end
                    K_END: begin
                        case (state_d)
                            ST_TLP: begin
                                lane_type_s = T_TLPEND;
                            end
                            ST_DLLP: begin
                                lane_type_s = T_DLLPEND;
                                lane_err_s  = (cnt_d != DLLP_C);
                            end
                            default: begin
                                lane_type_s = T_NONE;
                                lane_err_s  = 1'b1;
                            end
                        endcase
                        state_d = ST_IDLE;
                    end
                    K_EDB: begin
                        if (state_d == ST_TLP) begin
                            lane_type_s = T_TLPEDB;
                        end else begin
                            lane_type_s = T_NONE;
                            lane_err_s  = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                    K_PAD: begin
                        lane_type_s = T_NONE;
                    end
                    default: begin
                        lane_type_s = T_NONE;
                        lane_err_s  = 1'b1;
                        state_d     = ST_IDLE;
                    end
                endcase
            end else begin
                case (state_d)
                    ST_TLP: begin
                        if (cnt_d >= MAX_C) begin
                            // Byte MAX_TLP_BYTES+1 kills the TLP.
                            lane_type_s = T_NONE;
                            lane_err_s  = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            lane_type_s = T_DATA;
                            cnt_d       = cnt_d + CNT_ONE;
                        end
                    end
                    ST_DLLP: begin
                        // Over-long DLLPs keep typing data; the length error shows at END.
                        lane_type_s = T_DATA;
                        if (cnt_d != CNT_SAT) begin
                            cnt_d = cnt_d + CNT_ONE;
                        end else begin
                            cnt_d = CNT_SAT;
                        end
                    end
                    default: begin
                        lane_type_s = T_NONE;
                    end
                endcase
            end
            type_d[6*i +: 6] = lane_type_s;
            err_d[i]         = lane_err_s;
        end
    end

    // Output and framing-state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            type_q  <= {(6*LANES){1'b0}};
            valid_q <= {LANES{1'b0}};
            err_q   <= {LANES{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign type_out  = type_q;
    assign valid_out = valid_q;
    assign err_out   = err_q;
    assign state_out = state_q;

`ifdef PKT_ID_STATS_EN
    // Number of lanes whose type equals code.
    function automatic logic [15:0] count_type(input logic [6*LANES-1:0] t,
                                               input logic [5:0] code);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < LANES; i++) begin
            if (t[6*i +: 6] == code) begin
                n = n + 16'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Number of set bits in the per-lane error vector.
    function automatic logic [15:0] count_bits(input logic [LANES-1:0] v);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) begin
                n = n + 16'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Add with saturation at 0xFFFF.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] tlp_cnt_q, tlp_cnt_d;
    logic [15:0] dllp_cnt_q, dllp_cnt_d;
    logic [15:0] edb_cnt_q, edb_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Next statistics values from this cycle's lane classification.
    always_comb begin
        tlp_cnt_d  = sat_add(tlp_cnt_q,  count_type(type_d, T_TLPEND));
        dllp_cnt_d = sat_add(dllp_cnt_q, count_type(type_d, T_DLLPEND));
        edb_cnt_d  = sat_add(edb_cnt_q,  count_type(type_d, T_TLPEDB));
        err_cnt_d  = sat_add(err_cnt_q,  count_bits(err_d));
    end

    // Statistics registers, updated on the same edge as type_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tlp_cnt_q  <= 16'd0;
            dllp_cnt_q <= 16'd0;
            edb_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            tlp_cnt_q  <= tlp_cnt_d;
            dllp_cnt_q <= dllp_cnt_d;
            edb_cnt_q  <= edb_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tlp_cnt  = tlp_cnt_q;
    assign dllp_cnt = dllp_cnt_q;
    assign edb_cnt  = edb_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_packet_identifier_lanes.sv
// Scoreboard bench for packet_identifier_lanes (LANES=4, MAX_TLP_BYTES=8).
// The driver pushes hand-computed expectations as it drives each cycle; a
// separate monitor pops one entry after every clock edge and compares.

module tb_packet_identifier_lanes;

    localparam int LANES = 4;

    localparam logic [5:0] TN = 6'b000000;
    localparam logic [5:0] TD = 6'b100000;
    localparam logic [5:0] TS = 6'b010000;
    localparam logic [5:0] TE = 6'b001000;
    localparam logic [5:0] DE = 6'b000100;
    localparam logic [5:0] DS = 6'b000010;
    localparam logic [5:0] TB = 6'b000001;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] PAD = 8'hF7;

    logic                 clk;
    logic                 rst_n;
    logic [8*LANES-1:0]   data_in;
    logic [LANES-1:0]     dk_in;
    logic [LANES-1:0]     valid_in;
    logic [6*LANES-1:0]   type_out;
    logic [LANES-1:0]     valid_out;
    logic [LANES-1:0]     err_out;
    logic [1:0]           state_out;
`ifdef PKT_ID_STATS_EN
    logic [15:0]          tlp_cnt, dllp_cnt, edb_cnt, err_cnt;
`endif

    packet_identifier_lanes #(
        .LANES(LANES),
        .MAX_TLP_BYTES(8),
        .DLLP_BYTES(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .dk_in(dk_in),
        .valid_in(valid_in),
        .type_out(type_out),
        .valid_out(valid_out),
        .err_out(err_out),
`ifdef PKT_ID_STATS_EN
        .tlp_cnt(tlp_cnt),
        .dllp_cnt(dllp_cnt),
        .edb_cnt(edb_cnt),
        .err_cnt(err_cnt),
`endif
        .state_out(state_out)
    );

    typedef struct {
        logic [23:0] t;
        logic [3:0]  v;
        logic [3:0]  e;
        logic [1:0]  s;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int id,
                       input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    // Monitor: one output word per clock edge, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("type_out",  e.id, type_out,           e.t);
                chk("valid_out", e.id, {20'd0, valid_out}, {20'd0, e.v});
                chk("err_out",   e.id, {20'd0, err_out},   {20'd0, e.e});
                chk("state_out", e.id, {22'd0, state_out}, {22'd0, e.s});
            end
        end
    end

    // Drive one cycle; bytes/types are given lane 3 down to lane 0.
    task automatic drive(input logic rst_v,
                         input logic [7:0] b3, input logic [7:0] b2,
                         input logic [7:0] b1, input logic [7:0] b0,
                         input logic [3:0] k, input logic [3:0] v,
                         input logic [5:0] t3, input logic [5:0] t2,
                         input logic [5:0] t1, input logic [5:0] t0,
                         input logic [3:0] e, input logic [1:0] s);
        exp_t x;
        @(negedge clk);
        rst_n    = rst_v;
        data_in  = {b3, b2, b1, b0};
        dk_in    = k;
        valid_in = v;
        x.t  = {t3, t2, t1, t0};
        x.v  = rst_v ? v : 4'b0000;
        x.e  = e;
        x.s  = s;
        x.id = vec_id;
        vec_id++;
        exp_q.push_back(x);
    endtask

    task automatic drive_reset();
        drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              4'($urandom), 4'b1111, TN, TN, TN, TN, 4'b0000, 2'b00);
    endtask

    initial begin
        int budget;
        rst_n    = 1'b0;
        data_in  = 32'h0;
        dk_in    = 4'h0;
        valid_in = 4'h0;

        // reset with random valid lanes
        drive_reset();
        drive_reset();

        // DLLP, 6 data bytes across two cycles
        drive(1'b1, 8'h33, 8'h22, 8'h11, SDP, 4'b0001, 4'b1111, TD, TD, TD, DS, 4'b0000, 2'b10);
        drive(1'b1, END, 8'h66, 8'h55, 8'h44, 4'b1000, 4'b1111, DE, TD, TD, TD, 4'b0000, 2'b00);

        // DLLP with only 5 data bytes, then PAD while idle
        drive(1'b1, 8'h03, 8'h02, 8'h01, SDP, 4'b0001, 4'b1111, TD, TD, TD, DS, 4'b0000, 2'b10);
        drive(1'b1, PAD, END, 8'h05, 8'h04, 4'b1100, 4'b1111, TN, DE, TD, TD, 4'b0100, 2'b00);

        // PAD, PAD, STP, d / d, EDB, SDP, d
        drive(1'b1, 8'hA0, STP, PAD, PAD, 4'b0111, 4'b1111, TD, TS, TN, TN, 4'b0000, 2'b01);
        drive(1'b1, 8'hA2, SDP, EDB, 8'hA1, 4'b0110, 4'b1111, TD, DS, TB, TD, 4'b0000, 2'b10);

        // short DLLP ends (err), then END while idle (err); lanes 2,3 invalid
        drive(1'b1, END, STP, END, END, 4'b1111, 4'b0011, TN, TN, TN, DE, 4'b0011, 2'b00);

        // STP while in TLP, then a clean END
        drive(1'b1, 8'hB1, STP, 8'hB0, STP, 4'b0101, 4'b1111, TD, TS, TD, TS, 4'b0100, 2'b01);
        drive(1'b1, 8'h00, 8'h00, 8'h00, END, 4'b0001, 4'b0001, TN, TN, TN, TE, 4'b0000, 2'b00);

        // TLP overflow at MAX_TLP_BYTES=8: bytes 1..8 data, byte 9 error, END after it error
        drive(1'b1, 8'hC3, 8'hC2, 8'hC1, STP, 4'b0001, 4'b1111, TD, TD, TD, TS, 4'b0000, 2'b01);
        drive(1'b1, 8'hC7, 8'hC6, 8'hC5, 8'hC4, 4'b0000, 4'b1111, TD, TD, TD, TD, 4'b0000, 2'b01);
        drive(1'b1, END, 8'hCA, 8'hC9, 8'hC8, 4'b1000, 4'b1111, TN, TN, TN, TD, 4'b1010, 2'b00);

        // unknown K inside a TLP aborts it
        drive(1'b1, 8'hD1, 8'h1C, 8'hD0, STP, 4'b0101, 4'b1111, TN, TN, TD, TS, 4'b0100, 2'b00);

        // EDB while idle
        drive(1'b1, 8'h00, 8'h00, 8'h00, EDB, 4'b0001, 4'b0001, TN, TN, TN, TN, 4'b0001, 2'b00);

        // reset in the middle of a TLP clears the framing state
        drive(1'b1, 8'h00, 8'h00, 8'h00, STP, 4'b0001, 4'b0001, TN, TN, TN, TS, 4'b0000, 2'b01);
        drive_reset();
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'hE0, 4'b0000, 4'b0001, TN, TN, TN, TN, 4'b0000, 2'b00);

        @(negedge clk);
        valid_in = 4'b0000;
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
